// File: rtl/safety_pkg.sv
// Shared definitions for the amplifier safety latch: FSM state encodings,
// default trip persistence and event-counter width.
package safety_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    ON    = 2'b01,
    PEND  = 2'b10,
    FAULT = 2'b11
  } state_t;

  localparam int TRIP_CYCLES_DEF = 16;
  localparam int EVENT_CNT_W     = 8;

endpackage

// File: rtl/safety_amp_latch_trip_counter.sv
// Persistence counter for consecutive amp_disable samples; terminal flags the
// last count before a trip so the FSM can fault on the following high sample.
module trip_counter
  import safety_pkg::*;
#(
  parameter int TRIP_CYCLES = TRIP_CYCLES_DEF,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TRIP_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Increment is gated by terminal so the count can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !terminal) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == TERM);

endmodule

// File: rtl/safety_amp_latch.sv
// Amplifier enable latch with persistence-filtered fault trip and host clear.
// Optional trip event counter is built only with SAFETY_EVENT_CNT_EN defined.
module safety_amp_latch
  import safety_pkg::*;
#(
  parameter int TRIP_CYCLES = TRIP_CYCLES_DEF,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       amp_disable,
  input  logic       enable_req,
  input  logic       fault_clr,
  output logic       amp_en,
  output logic       fault,
  output logic [1:0] state,
  output logic [7:0] event_cnt
);

  state_t cur, nxt;
  logic   nxt_amp_en, nxt_fault;
  logic   cnt_clear, cnt_inc, terminal;

  trip_counter #(
    .TRIP_CYCLES(TRIP_CYCLES),
    .CNT_W      (CNT_W)
  ) u_trip_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .terminal(terminal)
  );

  always_comb begin
    nxt     = cur;
    cnt_inc = 1'b0;
    case (cur)
      OFF: begin
        if (enable_req && !amp_disable) nxt = ON;
      end
      ON: begin
        if (!enable_req) begin
          nxt = OFF;
        end else if (amp_disable) begin
          nxt     = PEND;
          cnt_inc = 1'b1;
        end
      end
      PEND: begin
        if (!enable_req)       nxt = OFF;
        else if (!amp_disable) nxt = ON;
        else if (terminal)     nxt = FAULT;
        else                   cnt_inc = 1'b1;
      end
      FAULT: begin
        if (fault_clr && !enable_req) nxt = OFF;
      end
      default: nxt = OFF;
    endcase
    // The run count only survives while the FSM stays in PEND.
    cnt_clear  = (nxt != PEND);
    nxt_amp_en = (nxt == ON) || (nxt == PEND);
    nxt_fault  = (nxt == FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur    <= OFF;
      amp_en <= 1'b0;
      fault  <= 1'b0;
    end else begin
      cur    <= nxt;
      amp_en <= nxt_amp_en;
      fault  <= nxt_fault;
    end
  end

  assign state = cur;

`ifdef SAFETY_EVENT_CNT_EN
  logic [EVENT_CNT_W-1:0] evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt <= '0;
    end else if ((nxt == FAULT) && (cur != FAULT) && (evt != '1)) begin
      evt <= evt + EVENT_CNT_W'(1);
    end
  end

  assign event_cnt = evt;
`else
  assign event_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_safety_amp_latch.sv
// Testbench for safety_amp_latch: directed scenarios plus randomized traffic
// checked against a run-length reference model.
module tb_safety_amp_latch;

  localparam int TRIP = 16;
`ifdef SAFETY_EVENT_CNT_EN
  localparam bit EVT_EN = 1'b1;
`else
  localparam bit EVT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, amp_disable, enable_req, fault_clr;
  logic       amp_en, fault;
  logic [1:0] state;
  logic [7:0] event_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=off 1=on 2=pending 3=fault, run = consecutive highs.
  int m_state, m_run, m_evt;

  always #5 clk = ~clk;

  safety_amp_latch dut (
    .clk        (clk),
    .reset      (reset),
    .amp_disable(amp_disable),
    .enable_req (enable_req),
    .fault_clr  (fault_clr),
    .amp_en     (amp_en),
    .fault      (fault),
    .state      (state),
    .event_cnt  (event_cnt)
  );

  task automatic model_reset();
    m_state = 0;
    m_run   = 0;
    m_evt   = 0;
  endtask

  task automatic model_step(input logic ad, input logic en, input logic clr);
    if (m_state == 3) begin
      if (clr && !en) m_state = 0;
    end else if (!en) begin
      m_state = 0;
      m_run   = 0;
    end else if (m_state == 0) begin
      if (!ad) m_state = 1;
    end else begin
      m_run = ad ? m_run + 1 : 0;
      if (m_run >= TRIP) begin
        m_state = 3;
        m_run   = 0;
        if (EVT_EN && m_evt < 255) m_evt++;
      end else begin
        m_state = (m_run > 0) ? 2 : 1;
      end
    end
  endtask

  task automatic step(input logic ad, input logic en, input logic clr);
    amp_disable = ad;
    enable_req  = en;
    fault_clr   = clr;
    @(posedge clk);
    model_step(ad, en, clr);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    amp_disable = 1'b0; enable_req = 1'b0; fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({state, amp_en, fault, event_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got %h expected 000", {state, amp_en, fault, event_cnt});
    end
    reset = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if ({state, amp_en, fault} !== 4'b0000) begin
      errors++;
      $display("FAIL off_idle: got %b expected 0000", {state, amp_en, fault});
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if ({state, amp_en, fault} !== 4'b0000) begin
      errors++;
      $display("FAIL off_enable_blocked: got %b expected 0000", {state, amp_en, fault});
    end
  endtask

  task automatic test_enable();
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if ({state, amp_en, fault} !== 4'b0110) begin
      errors++;
      $display("FAIL enable_on: got %b expected 0110", {state, amp_en, fault});
    end
  endtask

  task automatic test_glitch();
    for (int i = 1; i <= TRIP - 1; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if ({state, amp_en, fault} !== 4'b1010) begin
        errors++;
        $display("FAIL glitch_pend[%0d]: got %b expected 1010", i, {state, amp_en, fault});
      end
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if ({state, amp_en, fault} !== 4'b0110) begin
      errors++;
      $display("FAIL glitch_return_on: got %b expected 0110", {state, amp_en, fault});
    end
  endtask

  task automatic test_trip();
    logic [7:0] exp_evt;
    exp_evt = EVT_EN ? 8'd1 : 8'd0;
    for (int i = 1; i <= TRIP; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i == TRIP - 1) begin
        checks++;
        if ({state, amp_en, fault} !== 4'b1010) begin
          errors++;
          $display("FAIL trip_pre_edge: got %b expected 1010", {state, amp_en, fault});
        end
      end
    end
    checks++;
    if ({state, amp_en, fault, event_cnt} !== {4'b1101, exp_evt}) begin
      errors++;
      $display("FAIL trip_fault: got %h expected %h", {state, amp_en, fault, event_cnt}, {4'b1101, exp_evt});
    end
  endtask

  task automatic test_fault_clear();
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if ({state, amp_en, fault} !== 4'b1101) begin
      errors++;
      $display("FAIL clr_with_enable: got %b expected 1101", {state, amp_en, fault});
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if ({state, amp_en, fault} !== 4'b1101) begin
      errors++;
      $display("FAIL fault_holds: got %b expected 1101", {state, amp_en, fault});
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if ({state, amp_en, fault} !== 4'b0000) begin
      errors++;
      $display("FAIL clr_to_off: got %b expected 0000", {state, amp_en, fault});
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp_evt;
    exp_evt = EVT_EN ? 8'd1 : 8'd0;
    step(1'b0, 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b1, 1'b0);
    checks++;
    if ({state, amp_en, fault} !== 4'b1010) begin
      errors++;
      $display("FAIL areset_pend: got %b expected 1010", {state, amp_en, fault});
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({state, amp_en, fault, event_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL areset_immediate: got %h expected 000", {state, amp_en, fault, event_cnt});
    end
    reset = 1'b0;
    model_reset();
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if ({state, amp_en, fault} !== 4'b0110) begin
      errors++;
      $display("FAIL areset_reenable: got %b expected 0110", {state, amp_en, fault});
    end
    for (int i = 1; i <= TRIP; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i == TRIP - 1) begin
        checks++;
        if ({state, amp_en, fault} !== 4'b1010) begin
          errors++;
          $display("FAIL areset_full_count: got %b expected 1010", {state, amp_en, fault});
        end
      end
    end
    checks++;
    if ({state, amp_en, fault, event_cnt} !== {4'b1101, exp_evt}) begin
      errors++;
      $display("FAIL areset_retrip: got %h expected %h", {state, amp_en, fault, event_cnt}, {4'b1101, exp_evt});
    end
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic       ad, en, clr;
    int         burst;
    logic [1:0] ms;
    logic [7:0] me;
    burst = 0;
    ad    = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (burst == 0) begin
        ad    = ($urandom_range(0, 2) != 0);
        burst = $urandom_range(1, 24);
      end
      burst--;
      en  = ($urandom_range(0, 39) != 0);
      clr = ($urandom_range(0, 9) == 0);
      step(ad, en, clr);
      ms = m_state[1:0];
      me = m_evt[7:0];
      checks++;
      if ({state, amp_en, fault, event_cnt} !== {ms, (ms == 2'd1 || ms == 2'd2), (ms == 2'd3), me}) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", c, {state, amp_en, fault, event_cnt},
                 {ms, (ms == 2'd1 || ms == 2'd2), (ms == 2'd3), me});
      end
    end
  endtask

  task automatic test_saturation();
    int         base, e;
    logic [7:0] exp_evt;
    step(1'b0, 1'b0, 1'b1);
    base = m_evt;
    for (int t = 1; t <= 300; t++) begin
      step(1'b0, 1'b1, 1'b0);
      repeat (TRIP) step(1'b1, 1'b1, 1'b0);
      e       = EVT_EN ? ((base + t > 255) ? 255 : base + t) : 0;
      exp_evt = e[7:0];
      checks++;
      if ({state, amp_en, fault, event_cnt} !== {4'b1101, exp_evt}) begin
        errors++;
        $display("FAIL sat_trip[%0d]: got %h expected %h", t, {state, amp_en, fault, event_cnt}, {4'b1101, exp_evt});
      end
      step(1'b0, 1'b0, 1'b1);
    end
    exp_evt = EVT_EN ? 8'hFF : 8'h00;
    checks++;
    if (event_cnt !== exp_evt) begin
      errors++;
      $display("FAIL sat_final: got %h expected %h", event_cnt, exp_evt);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_enable();
    test_glitch();
    test_trip();
    test_fault_clear();
    test_async_reset();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
